// File: rtl/mul_pkg.sv
// Shared definitions for the FP multiplier retire stage: status bit positions,
// default field widths, the buffered entry layout and the canonical quiet NaN.
package mul_pkg;

    localparam int ST_NV = 4;
    localparam int ST_DZ = 3;
    localparam int ST_OF = 2;
    localparam int ST_UF = 1;
    localparam int ST_NX = 0;

    localparam int MUL_EXPO_W = 8;
    localparam int MUL_MANT_W = 23;
    localparam int MUL_ID_W   = 4;
    localparam int MUL_RES_W  = MUL_EXPO_W + MUL_MANT_W + 1;

    typedef struct packed {
        logic [MUL_RES_W-1:0] res;
        logic [4:0]           status;
        logic [MUL_ID_W-1:0]  id;
    } mul_entry_t;

    // Canonical quiet NaN right-aligned in 64 bits: sign 0, expo all-ones, mant MSB set.
    function automatic logic [63:0] canon_qnan(input int expo_w, input int mant_w);
        logic [63:0] q;
        for (int i = 0; i < 64; i++) begin
            if ((i >= mant_w) && (i < mant_w + expo_w)) begin
                q[i] = 1'b1;
            end else if (i == mant_w - 1) begin
                q[i] = 1'b1;
            end else begin
                q[i] = 1'b0;
            end
        end
        return q;
    endfunction

endpackage

// File: rtl/mul_retire_fifo.sv
// Generic DEPTH x W synchronous FIFO with wrap-bit pointers; head data is read
// combinationally and forced to zero while empty.
module mul_retire_fifo #(
    parameter int DEPTH = 2,
    parameter int W     = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push_valid,
    output logic         push_ready,
    input  logic [W-1:0] push_data,
    output logic         pop_valid,
    input  logic         pop_ready,
    output logic [W-1:0] pop_data
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0]  wr_ptr_r;
    logic [AW:0]  rd_ptr_r;
    logic [W-1:0] mem_r [DEPTH];
    logic         empty_s;
    logic         full_s;
    logic         push_s;
    logic         pop_s;

    assign empty_s    = (wr_ptr_r == rd_ptr_r);
    assign full_s     = (wr_ptr_r[AW-1:0] == rd_ptr_r[AW-1:0]) && (wr_ptr_r[AW] != rd_ptr_r[AW]);
    assign push_ready = !full_s;
    assign pop_valid  = !empty_s;
    assign push_s     = push_valid && !full_s;
    assign pop_s      = pop_ready && !empty_s;

    // Pointer update; full/empty depend only on these registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_r <= {(AW+1){1'b0}};
            rd_ptr_r <= {(AW+1){1'b0}};
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + (AW+1)'(1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + (AW+1)'(1);
            end
        end
    end

    // Entry storage; intentionally not reset.
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem_r[wr_ptr_r[AW-1:0]] <= push_data;
        end
    end

    // Head read, gated so nothing stale leaks out while empty.
    always_comb begin
        pop_data = {W{1'b0}};
        if (!empty_s) begin
            pop_data = mem_r[rd_ptr_r[AW-1:0]];
        end else begin
            pop_data = {W{1'b0}};
        end
    end

endmodule

// File: rtl/mul_retire.sv
// Retire stage for the FP multiplier: result FIFO, sticky fflags and retire counter.
// Define MUL_RETIRE_CANON_NAN_EN to store every pushed NaN as the canonical quiet NaN.
module mul_retire
    import mul_pkg::*;
#(
    parameter int EXPO_W = MUL_EXPO_W,
    parameter int MANT_W = MUL_MANT_W,
    parameter int DEPTH  = 2,
    parameter int ID_W   = MUL_ID_W,
    parameter int CNT_W  = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [EXPO_W+MANT_W:0]   in_res,
    input  logic [4:0]               in_status,
    input  logic [ID_W-1:0]          in_id,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [EXPO_W+MANT_W:0]   out_res,
    output logic [4:0]               out_status,
    output logic [ID_W-1:0]          out_id,
    input  logic                     flags_clr,
    output logic [4:0]               fflags,
    output logic [CNT_W-1:0]         retired_cnt
);

    localparam int RES_W = EXPO_W + MANT_W + 1;
    localparam int ENT_W = RES_W + 5 + ID_W;

    logic [RES_W-1:0] store_res_s;
    logic [ENT_W-1:0] head_s;
    logic             push_s;
    logic             pop_s;
    logic [4:0]       fflags_nxt_s;
    logic [4:0]       fflags_r;
    logic [CNT_W-1:0] cnt_r;

`ifdef MUL_RETIRE_CANON_NAN_EN
    localparam logic [RES_W-1:0] QNAN = RES_W'(canon_qnan(EXPO_W, MANT_W));

    logic is_nan_s;

    // NaN canonicalisation at accept time; status is passed through untouched.
    always_comb begin
        is_nan_s = (&in_res[RES_W-2:MANT_W]) && (|in_res[MANT_W-1:0]);
        if (is_nan_s) begin
            store_res_s = QNAN;
        end else begin
            store_res_s = in_res;
        end
    end
`else
    assign store_res_s = in_res;
`endif

    mul_retire_fifo #(
        .DEPTH (DEPTH),
        .W     (ENT_W)
    ) u_fifo (
        .clk        (clk),
        .rst_n      (rst_n),
        .push_valid (in_valid),
        .push_ready (in_ready),
        .push_data  ({store_res_s, in_status, in_id}),
        .pop_valid  (out_valid),
        .pop_ready  (out_ready),
        .pop_data   (head_s)
    );

    assign push_s      = in_valid && in_ready;
    assign pop_s       = out_valid && out_ready;
    assign out_res     = head_s[ENT_W-1 -: RES_W];
    assign out_status  = head_s[ID_W+4 -: 5];
    assign out_id      = head_s[ID_W-1:0];
    assign fflags      = fflags_r;
    assign retired_cnt = cnt_r;

    // Sticky flags: clear first, then OR in the accepted status so a same-cycle push survives.
    always_comb begin
        fflags_nxt_s = fflags_r;
        if (flags_clr) begin
            fflags_nxt_s = 5'd0;
        end else begin
            fflags_nxt_s = fflags_r;
        end
        if (push_s) begin
            fflags_nxt_s = fflags_nxt_s | in_status;
        end else begin
            fflags_nxt_s = fflags_nxt_s;
        end
    end

    // Flag and retire-counter registers; the counter wraps naturally.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fflags_r <= 5'd0;
            cnt_r    <= {CNT_W{1'b0}};
        end else begin
            fflags_r <= fflags_nxt_s;
            if (pop_s) begin
                cnt_r <= cnt_r + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_mul_retire.sv
// Directed self-checking bench for mul_retire (default parameters); expected
// NaN handling follows MUL_RETIRE_CANON_NAN_EN.
module tb_mul_retire;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_res;
    logic [4:0]  in_status;
    logic [3:0]  in_id;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_res;
    logic [4:0]  out_status;
    logic [3:0]  out_id;
    logic        flags_clr;
    logic [4:0]  fflags;
    logic [15:0] retired_cnt;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    mul_retire dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_res      (in_res),
        .in_status   (in_status),
        .in_id       (in_id),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_res     (out_res),
        .out_status  (out_status),
        .out_id      (out_id),
        .flags_clr   (flags_clr),
        .fflags      (fflags),
        .retired_cnt (retired_cnt)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [31:0] res, input logic [4:0] st, input logic [3:0] id);
        in_valid  = 1'b1;
        in_res    = res;
        in_status = st;
        in_id     = id;
    endtask

    logic [31:0] nan_exp;

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_res    = 32'h0;
        in_status = 5'd0;
        in_id     = 4'd0;
        out_ready = 1'b0;
        flags_clr = 1'b0;
        #12;
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_in_ready", 64'(in_ready), 64'd1);
        check("rst_fflags", 64'(fflags), 64'd0);
        check("rst_cnt", 64'(retired_cnt), 64'd0);
        check("rst_out_res", 64'(out_res), 64'd0);
        rst_n = 1'b1;
        tick();

        // Back-to-back pushes with consumer always ready
        out_ready = 1'b1;
        drive(32'h3F800000, 5'd0, 4'd1);
        #1;
        check("s1_no_bypass", 64'(out_valid), 64'd0);
        tick();
        check("s1_valid", 64'(out_valid), 64'd1);
        check("s1_res0", 64'(out_res), 64'h3F800000);
        check("s1_id0", 64'(out_id), 64'd1);
        drive(32'h40000000, 5'd0, 4'd2);
        tick();
        check("s1_res1", 64'(out_res), 64'h40000000);
        check("s1_cnt1", 64'(retired_cnt), 64'd1);
        drive(32'h40400000, 5'd0, 4'd3);
        tick();
        check("s1_res2", 64'(out_res), 64'h40400000);
        check("s1_id2", 64'(out_id), 64'd3);
        in_valid = 1'b0;
        tick();
        check("s1_empty", 64'(out_valid), 64'd0);
        check("s1_cnt3", 64'(retired_cnt), 64'd3);

        // Backpressure: fill, refuse a third, then drain
        out_ready = 1'b0;
        drive(32'h11111111, 5'd0, 4'd5);
        tick();
        check("s2_valid", 64'(out_valid), 64'd1);
        check("s2_ready1", 64'(in_ready), 64'd1);
        drive(32'h22222222, 5'd0, 4'd6);
        tick();
        check("s2_full", 64'(in_ready), 64'd0);
        drive(32'h33333333, 5'd0, 4'd7);
        tick();
        check("s2_still_full", 64'(in_ready), 64'd0);
        check("s2_head_held", 64'(out_id), 64'd5);
        check("s2_head_res", 64'(out_res), 64'h11111111);
        out_ready = 1'b1;
        tick();
        check("s2_ready_back", 64'(in_ready), 64'd1);
        check("s2_head_b", 64'(out_id), 64'd6);
        check("s2_cnt4", 64'(retired_cnt), 64'd4);
        in_valid = 1'b0;
        tick();
        check("s2_no_third", 64'(out_valid), 64'd0);
        check("s2_cnt5", 64'(retired_cnt), 64'd5);

        // Sticky flags accumulate at accept time
        drive(32'h3F800000, 5'b00001, 4'd1);
        tick();
        check("s3_flags_nx", 64'(fflags), 64'b00001);
        drive(32'h3F800000, 5'b00100, 4'd2);
        tick();
        check("s3_flags_acc", 64'(fflags), 64'b00101);
        flags_clr = 1'b1;
        drive(32'h3F800000, 5'b10000, 4'd3);
        tick();
        check("s3_clr_push", 64'(fflags), 64'b10000);
        check("s3_cnt7", 64'(retired_cnt), 64'd7);
        flags_clr = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        tick();
        check("s3_head_st", 64'(out_status), 64'b10000);
        flags_clr = 1'b1;
        tick();
        check("s3_clr_only", 64'(fflags), 64'd0);
        check("s3_st_kept", 64'(out_status), 64'b10000);
        flags_clr = 1'b0;

        // Asynchronous reset with two entries buffered
        drive(32'h44444444, 5'b00010, 4'd9);
        tick();
        in_valid = 1'b0;
        check("s4_full", 64'(in_ready), 64'd0);
        check("s4_flags", 64'(fflags), 64'b00010);
        #2;
        rst_n = 1'b0;
        #1;
        check("s4_rst_valid", 64'(out_valid), 64'd0);
        check("s4_rst_flags", 64'(fflags), 64'd0);
        check("s4_rst_cnt", 64'(retired_cnt), 64'd0);
        check("s4_rst_ready", 64'(in_ready), 64'd1);
        #2;
        rst_n = 1'b1;
        tick();
        check("s4_post_empty", 64'(out_valid), 64'd0);

        // NaN handling
`ifdef MUL_RETIRE_CANON_NAN_EN
        nan_exp = 32'h7FC00000;
`else
        nan_exp = 32'hFFA00001;
`endif
        drive(32'hFFA00001, 5'b10001, 4'd4);
        tick();
        in_valid = 1'b0;
        check("s5_nan_res", 64'(out_res), 64'(nan_exp));
        check("s5_nan_st", 64'(out_status), 64'b10001);
        out_ready = 1'b1;
        drive(32'h7F800000, 5'b00000, 4'd8);
        tick();
        in_valid = 1'b0;
        check("s5_inf_res", 64'(out_res), 64'h7F800000);
        tick();
        check("s5_empty_gate", 64'(out_res), 64'd0);
        check("s5_cnt2", 64'(retired_cnt), 64'd2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/mul_retire.md
Name: mul_retire

Overview:
- Downstream retire stage for the 3-stage FP multiplier; consumes the packed result `res` and 5-bit `status` produced by the final pipe stage.
- Buffers results in a small FIFO with valid/ready handshake so the consumer can stall without stalling the multiplier datapath.
- Accumulates IEEE sticky exception flags (fflags) and counts retired operations.

Parameters:
- EXPO_W, 8, exponent width; must match the multiplier.
- MANT_W, 23, stored mantissa width; must match the multiplier.
- DEPTH, 2, FIFO entries; power of two, >= 2.
- ID_W, 4, width of the opaque tag carried alongside each result.
- CNT_W, 16, width of the retired-operation counter.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  result from final multiplier stage valid
- in_ready  out  1  block can accept a result this cycle
- in_res  in  EXPO_W+MANT_W+1  packed {sign,expo,mant}
- in_status  in  5  {NV,DZ,OF,UF,NX}, bit 4 = NV, bit 0 = NX
- in_id  in  ID_W  tag
- out_valid  out  1  head entry valid
- out_ready  in  1  consumer accepts head
- out_res  out  EXPO_W+MANT_W+1  head result
- out_status  out  5  head status
- out_id  out  ID_W  head tag
- flags_clr  in  1  clear sticky flags
- fflags  out  5  sticky OR of accepted status
- retired_cnt  out  CNT_W  number of pops since reset

Behaviour:
- Clock and reset: one clock `clk`; reset `rst_n` is asynchronous and active-low.
- Reset values: pointers 0, FIFO empty, fflags 0, retired_cnt 0, out_valid 0. Storage is not reset; out_res/out_status/out_id read as 0 while empty (gated).
- Push/pop events:
  - push = in_valid & in_ready.
  - pop = out_valid & out_ready.
- Pointers: wr_ptr/rd_ptr of width log2(DEPTH)+1, with the MSB as wrap bit.
  - empty when the pointers are equal.
  - full when the low bits are equal and the MSBs differ.
  - Pointers wrap naturally modulo 2*DEPTH.
- Ready/valid rules:
  - in_ready = !full, computed from registered state only; no push on a full FIFO even if a pop occurs in the same cycle.
  - out_valid = !empty. Head data is driven combinationally from storage[rd_ptr].
- Latency: minimum 1 cycle from push to out_valid. A result pushed in cycle N is visible in cycle N+1.
- Simultaneous push and pop when not full and not empty: both pointers advance; occupancy is unchanged.
- Push into empty with out_ready=1: no same-cycle bypass; the entry appears in the next cycle.
- Ordering: results retire strictly in order. Once out_valid=1, the head is held stable until popped.
- Sticky flags: next fflags = (flags_clr ? 0 : fflags) | (push ? in_status : 0).
  - Flags accumulate at accept time, not retire time.
  - On a simultaneous clr and push, the pushed flags survive.
- Counter: retired_cnt increments by 1 on each pop and wraps from 2^CNT_W-1 to 0.
- Protocol: in_valid deasserting without a handshake is legal (the upstream pipe has no hold obligation). The upstream stalls when in_ready=0.
- Reset mid-operation: all buffered entries are discarded; fflags and the counter clear immediately (asynchronously).

Optional Feature:
- Macro: MUL_RETIRE_CANON_NAN_EN.
- When defined, any pushed in_res with expo all-ones and mant != 0 is stored as the canonical quiet NaN: sign 0, expo all-ones, mant MSB 1, remaining bits 0. in_status is unaffected.
- When undefined, in_res is stored unmodified, preserving payload and sign as generated by the NaN-judge logic.

Decomposition:
- Shared package mul_pkg:
  - status bit index constants (ST_NV=4, ST_DZ=3, ST_OF=2, ST_UF=1, ST_NX=0);
  - function canon_qnan(EXPO_W, MANT_W);
  - packed struct for a result entry {res, status, id}.
- One natural sub-module: mul_retire_fifo, a generic DEPTH x entry synchronous FIFO with wrap-bit pointers. mul_retire wraps it with flag accumulation, the counter and NaN canonicalisation.

Test Plan:
- Reset then 3 back-to-back pushes with out_ready=1, res=0x3F800000/0x40000000/0x40400000 -> out_valid rises 1 cycle after the first push; outputs appear in order; retired_cnt=3.
- out_ready=0, push 2 results (DEPTH=2) -> in_ready=0 after the second push; a third in_valid is not accepted. Raise out_ready -> head pops and in_ready returns to 1 the next cycle.
- Push status 5'b00001 then 5'b00100 -> fflags=5'b00101. Then flags_clr together with a push of status 5'b10000 -> fflags=5'b10000.
- Hold flags_clr with no push -> fflags=0 next cycle. Status of the buffered entries is unchanged in out_status.
- Assert rst_n low mid-stream with 2 entries buffered -> out_valid=0, fflags=0 and retired_cnt=0 immediately, without a clock edge.
- With MUL_RETIRE_CANON_NAN_EN, push 0xFFA00001 -> out_res=0x7FC00000. Without the macro -> out_res=0xFFA00001.
